// File: rtl/gpr.sv
// 32x32 register file: two async read ports, one sync write port, write-through bypass.
// Define GPR_ZERO_REG_EN to hardwire register 0 to zero.
module gpr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_0,
    output logic [DATA_W-1:0] rd_data_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    input  logic              we_,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;
    logic              byp_0;
    logic              byp_1;

`ifdef GPR_ZERO_REG_EN
    assign wr_ok = !we_ && (wr_addr != '0);
`else
    assign wr_ok = !we_;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Bypass ignores reset so decode sees in-flight data even then
    assign byp_0 = wr_ok && (wr_addr == rd_addr_0);
    assign byp_1 = wr_ok && (wr_addr == rd_addr_1);

    always_comb begin
        rd_data_0 = regs[rd_addr_0];
        if (byp_0) begin
            rd_data_0 = wr_data;
        end
`ifdef GPR_ZERO_REG_EN
        if (rd_addr_0 == '0) begin
            rd_data_0 = '0;
        end
`endif
    end

    always_comb begin
        rd_data_1 = regs[rd_addr_1];
        if (byp_1) begin
            rd_data_1 = wr_data;
        end
`ifdef GPR_ZERO_REG_EN
        if (rd_addr_1 == '0) begin
            rd_data_1 = '0;
        end
`endif
    end

endmodule

// File: tb/tb_gpr.sv
// Testbench for gpr: directed and random stimulus checked
// against an array-based reference model of the register file.
module tb_gpr;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_addr_0;
    logic [31:0] rd_data_0;
    logic [4:0]  rd_addr_1;
    logic [31:0] rd_data_1;
    logic        we_;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int vectors;
    int miscompares;
    logic [31:0] mdl [32];

    gpr dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_0 (rd_addr_0),
        .rd_data_0 (rd_data_0),
        .rd_addr_1 (rd_addr_1),
        .rd_data_1 (rd_data_1),
        .we_       (we_),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
`ifdef GPR_ZERO_REG_EN
        if (a == 5'd0) return 32'h0;
`endif
        if (!we_ && wr_addr == a) return wr_data;
        return mdl[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ports(input string tag);
        chk({tag, "_p0"}, rd_data_0, expect_rd(rd_addr_0));
        chk({tag, "_p1"}, rd_data_1, expect_rd(rd_addr_1));
    endtask

    // One clock: model commits the write at the rising edge
    task automatic cyc();
        @(posedge clk);
        if (reset && !we_) begin
`ifdef GPR_ZERO_REG_EN
            if (wr_addr != 5'd0) mdl[wr_addr] = wr_data;
`else
            mdl[wr_addr] = wr_data;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        reset = 1'b0;
        we_ = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h0;
        rd_addr_0 = 5'd3;
        rd_addr_1 = 5'd31;

        #25;
        chk("rst_r3", rd_data_0, 32'h0);
        chk("rst_r31", rd_data_1, 32'h0);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rd_addr_0 = 5'(i);
            rd_addr_1 = 5'(31 - i);
            #1;
            chk("post_rst_p0", rd_data_0, 32'h0);
            chk("post_rst_p1", rd_data_1, 32'h0);
        end

        we_ = 1'b0;
        wr_addr = 5'd5;
        wr_data = 32'h1234_5678;
        cyc();
        we_ = 1'b1;
        rd_addr_0 = 5'd5;
        rd_addr_1 = 5'd5;
        #1;
        chk("wr5_p0", rd_data_0, 32'h1234_5678);
        chk("wr5_p1", rd_data_1, 32'h1234_5678);
        rd_addr_1 = 5'd6;
        #1;
        chk("rd6", rd_data_1, 32'h0);

        we_ = 1'b0;
        wr_addr = 5'd9;
        wr_data = 32'hDEAD_BEEF;
        rd_addr_0 = 5'd9;
        rd_addr_1 = 5'd10;
        #1;
        chk("byp9", rd_data_0, 32'hDEAD_BEEF);
        chk("byp10", rd_data_1, 32'h0);
        cyc();
        we_ = 1'b1;
        #1;
        chk("held9", rd_data_0, 32'hDEAD_BEEF);

        wr_addr = 5'd7;
        wr_data = 32'hFFFF_FFFF;
        rd_addr_0 = 5'd7;
        #1;
        chk("nowe_byp7", rd_data_0, 32'h0);
        cyc();
        chk("nowe_r7", rd_data_0, 32'h0);

        for (int i = 0; i < 32; i++) begin
            we_ = 1'b0;
            wr_addr = 5'(i);
            wr_data = 32'(i * 3);
            rd_addr_0 = 5'(i);
            #1;
            chk_ports("sweep_byp");
            cyc();
        end
        we_ = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_addr_0 = 5'(i);
            rd_addr_1 = 5'(31 - i);
            #1;
            chk_ports("sweep_rd");
        end
        we_ = 1'b0;
        wr_addr = 5'd12;
        wr_data = 32'd100;
        cyc();
        we_ = 1'b1;
        rd_addr_0 = 5'd12;
        #1;
        chk("r12_100", rd_data_0, 32'd100);

        for (int n = 0; n < 300; n++) begin
            we_ = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            rd_addr_0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr_1 = ($urandom_range(0, 3) == 0) ? rd_addr_0 : 5'($urandom);
            #1;
            chk_ports("rand");
            cyc();
        end

        we_ = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'hAA;
        cyc();
        we_ = 1'b1;
        rd_addr_0 = 5'd0;
        #1;
`ifdef GPR_ZERO_REG_EN
        chk("r0_wr", rd_data_0, 32'h0);
`else
        chk("r0_wr", rd_data_0, 32'hAA);
`endif

        rd_addr_0 = 5'd12;
        rd_addr_1 = 5'd30;
        #1;
        chk_ports("pre_arst");
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        #1;
        chk("arst_p0", rd_data_0, 32'h0);
        chk("arst_p1", rd_data_1, 32'h0);
        we_ = 1'b0;
        wr_addr = 5'd4;
        wr_data = 32'h5A5A_0004;
        rd_addr_0 = 5'd4;
        #1;
        chk("rst_byp", rd_data_0, 32'h5A5A_0004);
        cyc();
        reset = 1'b1;
        we_ = 1'b1;
        #1;
        chk("rst_nowr", rd_data_0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
